// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM state encodings and fetch-unit defaults.
package cpu_defs;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ERR   = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'd1;
  localparam int          TIMEOUT_DEFAULT  = 16;

endpackage

// File: rtl/pc_fetch_unit_fetch_timer.sv
// Fetch watchdog: counts enabled cycles and flags the cycle whose count would
// reach TIMEOUT. Clear has priority over enable.
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int             W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is the edge on which the count would become TIMEOUT.
  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, fetches over an imem req/ack handshake, presents
// the instruction until downstream retires it, and flags fetch timeouts.
module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] NPC,
  input  logic        Hold,
  input  logic        IAck,
  input  logic [31:0] IData,
  output logic        IReq,
  output logic [31:0] IAddr,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        FetchErr,
  output logic [31:0] RetireCnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] retireCnt_q, retireCnt_d;

  logic inFetch;
  logic ackTaken;
  logic retire;
  logic timerExpire;

  assign inFetch  = (state_q == S_FETCH);
  assign ackTaken = inFetch && IAck;
  assign retire   = (state_q == S_EXEC) && !Hold;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk_i    (Clk),
    .reset_i  (Reset),
    .clear_i  (!inFetch),
    .enable_i (inFetch && !IAck),
    .expire_o (timerExpire)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack arriving on the expiry edge wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (IAck) begin
          state_d = S_EXEC;
        end else if (timerExpire) begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        if (!Hold) begin
          state_d = S_FETCH;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IReq = inFetch;
  end

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    err_d       = err_q;
    retireCnt_d = retireCnt_q;
    if (ackTaken) begin
      instr_d = IData;
      valid_d = 1'b1;
    end
    if (timerExpire) begin
      err_d = 1'b1;
    end
    if (retire) begin
      pc_d        = NPC;
      retireCnt_d = retireCnt_q + 32'd1;
      valid_d     = 1'b0;
    end
    if (state_q == S_ERR) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      retireCnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      retireCnt_q <= retireCnt_d;
    end
  end

  assign IAddr      = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign FetchErr   = err_q;
  assign RetireCnt  = retireCnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: hand-computed expectations for fetch,
// retire, hold, timeout, reset-override and PC wrap scenarios.
module tb_pc_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] NPC;
  logic        Hold;
  logic        IAck;
  logic [31:0] IData;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        FetchErr;
  logic [31:0] RetireCnt;

  logic        npcOverride;
  logic [31:0] npcValue;

  int testsRun;
  int testsFailed;

  pc_fetch_unit #(
    .RESET_PC (32'd1),
    .TIMEOUT  (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .NPC        (NPC),
    .Hold       (Hold),
    .IAck       (IAck),
    .IData      (IData),
    .IReq       (IReq),
    .IAddr      (IAddr),
    .PC         (PC),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .FetchErr   (FetchErr),
    .RetireCnt  (RetireCnt)
  );

  // Stand-in for the npc block: sequential PC unless a test forces a target.
  assign NPC = npcOverride ? npcValue : PC + 32'd1;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ack, input logic [31:0] data,
                               input logic hold);
    Reset = rst;
    IAck  = ack;
    IData = data;
    Hold  = hold;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    npcOverride = 1'b0;
    npcValue    = '0;

    // Test 1: reset, then zero-wait memory with sequential NPC
    applyStimulus(1'b1, 1'b1, 32'h8C01_0004, 1'b0);
    tick(2);
    Reset = 1'b0;
    checkOutput("rst_pc",     PC,                 32'd1);
    checkOutput("rst_instr",  Instr,              32'd0);
    checkOutput("rst_valid",  {31'd0, InstrValid}, 32'd0);
    checkOutput("rst_err",    {31'd0, FetchErr},   32'd0);
    checkOutput("rst_retire", RetireCnt,          32'd0);
    checkOutput("rst_ireq",   {31'd0, IReq},       32'd1);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("t1_iaddr", IAddr, 32'(k));
      checkOutput("t1_fetch_valid", {31'd0, InstrValid}, 32'd0);
      tick();
      checkOutput("t1_exec_valid", {31'd0, InstrValid}, 32'd1);
      checkOutput("t1_exec_instr", Instr, 32'h8C01_0004);
      checkOutput("t1_exec_ireq",  {31'd0, IReq}, 32'd0);
      tick();
    end
    checkOutput("t1_retire3", RetireCnt, 32'd3);
    checkOutput("t1_pc4",     PC,        32'd4);

    // Test 2: ack arrives after 5 cycles of request
    applyStimulus(1'b0, 1'b0, 32'h1234_5678, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t2_ireq_wait", {31'd0, IReq}, 32'd1);
      tick();
    end
    checkOutput("t2_not_valid", {31'd0, InstrValid}, 32'd0);
    IAck = 1'b1;
    tick();
    IAck = 1'b0;
    checkOutput("t2_instr", Instr, 32'h1234_5678);
    checkOutput("t2_valid", {31'd0, InstrValid}, 32'd1);
    checkOutput("t2_err",   {31'd0, FetchErr}, 32'd0);

    // Test 3: hold in EXEC keeps PC/Instr stable, then retires once
    npcOverride = 1'b1;
    npcValue    = 32'h0000_0040;
    Hold        = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("t3_hold_pc",    PC,        32'd4);
      checkOutput("t3_hold_instr", Instr,     32'h1234_5678);
      checkOutput("t3_hold_valid", {31'd0, InstrValid}, 32'd1);
      checkOutput("t3_hold_ret",   RetireCnt, 32'd3);
    end
    Hold = 1'b0;
    tick();
    checkOutput("t3_pc40",    PC,        32'h0000_0040);
    checkOutput("t3_retire4", RetireCnt, 32'd4);
    npcOverride = 1'b0;

    // Test 4: no ack -> error after exactly 16 fetch cycles
    IAck = 1'b0;
    tick(15);
    checkOutput("t4_err_before", {31'd0, FetchErr}, 32'd0);
    checkOutput("t4_ireq_before", {31'd0, IReq},    32'd1);
    tick();
    checkOutput("t4_err",  {31'd0, FetchErr}, 32'd1);
    checkOutput("t4_ireq", {31'd0, IReq},     32'd0);
    IAck  = 1'b1;
    IData = 32'hCAFE_F00D;
    tick(2);
    checkOutput("t4_err_sticky", {31'd0, FetchErr},   32'd1);
    checkOutput("t4_err_valid",  {31'd0, InstrValid}, 32'd0);
    checkOutput("t4_err_ireq",   {31'd0, IReq},       32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    Reset = 1'b0;
    checkOutput("t4_rst_err",   {31'd0, FetchErr}, 32'd0);
    checkOutput("t4_rst_iaddr", IAddr,             32'd1);
    checkOutput("t4_rst_ret",   RetireCnt,         32'd0);

    // Ack on the expiry edge wins over the timeout
    IData = 32'h5A5A_0001;
    tick(15);
    IAck = 1'b1;
    tick();
    IAck = 1'b0;
    checkOutput("t4b_ack_wins_err",   {31'd0, FetchErr},   32'd0);
    checkOutput("t4b_ack_wins_valid", {31'd0, InstrValid}, 32'd1);
    checkOutput("t4b_ack_wins_instr", Instr,               32'h5A5A_0001);
    tick();
    checkOutput("t4b_pc2", PC, 32'd2);

    // Test 5: reset with a concurrent ack drops the ack
    applyStimulus(1'b1, 1'b1, 32'hFFFF_0000, 1'b0);
    checkOutput("t5_ireq_pre", {31'd0, IReq}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_pc",     PC,                  32'd1);
    checkOutput("t5_valid",  {31'd0, InstrValid}, 32'd0);
    checkOutput("t5_retire", RetireCnt,           32'd0);
    checkOutput("t5_instr",  Instr,               32'd0);

    // Test 6: PC wrap through 0xFFFFFFFF and a spurious ack in EXEC
    npcOverride = 1'b1;
    npcValue    = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b1, 32'hAAAA_5555, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    checkOutput("t6_spurious_instr", Instr, 32'hAAAA_5555);
    Hold = 1'b0;
    IAck = 1'b0;
    tick();
    checkOutput("t6_iaddr_max", IAddr,     32'hFFFF_FFFF);
    checkOutput("t6_ret1",      RetireCnt, 32'd1);
    npcValue = 32'h0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0011, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_fetch_hold_instr", Instr, 32'h0000_0011);
    tick();
    checkOutput("t6_iaddr_zero", IAddr,             32'd0);
    checkOutput("t6_ret2",       RetireCnt,         32'd2);
    checkOutput("t6_no_err",     {31'd0, FetchErr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
